hex_digit_counter: RTL and testbench

//   Rate-divided 4-bit up/down digit counter: the upstream source of the nibble that drives
//   the seven-segment decoder, whose in3..in0 = digit[3:0] and whose outputs drive HEX0.
//   - Produces a steady count visible on the display at a selectable rate.
//   - Supports parallel load and count direction.
//   - Emits tick and wrap pulses for chaining a second digit.

---
 rtl/hex_digit_counter.sv | 96 +++++++++
 tb/tb_hex_digit_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit up/down digit counter with parallel load, feeding a seven-segment decoder.
// Define HEX_COUNTER_BCD_EN to count modulo 10 (clamping loads above 9); default counts modulo 16.
module hex_digit_counter #(
   parameter int CLK_HZ = 50_000_000,
   parameter int DIV_W  = 28
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic [1:0] speed,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] digit,
   output logic       tick,
   output logic       wrap
);

`ifdef HEX_COUNTER_BCD_EN
   localparam logic [3:0] MAX_DIGIT = 4'd9;
`else
   localparam logic [3:0] MAX_DIGIT = 4'd15;
`endif

   localparam logic [DIV_W-1:0] RELOAD_1HZ   = DIV_W'(CLK_HZ - 1);
   localparam logic [DIV_W-1:0] RELOAD_HALF  = DIV_W'(2 * CLK_HZ - 1);
   localparam logic [DIV_W-1:0] RELOAD_QUART = DIV_W'(4 * CLK_HZ - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] reload_val;
   logic [1:0]       speed_q;
   logic [3:0]       load_digit;
   logic [3:0]       next_digit;
   logic             step_wraps;

   always_comb begin
      case (speed)
         2'b00:   reload_val = '0;
         2'b01:   reload_val = RELOAD_1HZ;
         2'b10:   reload_val = RELOAD_HALF;
         default: reload_val = RELOAD_QUART;
      endcase
   end

   always_comb begin
      load_digit = load_value;
`ifdef HEX_COUNTER_BCD_EN
      if (load_value > MAX_DIGIT)
         load_digit = MAX_DIGIT;
`endif
   end

   // Wrap is detected on the current digit so it lines up with the step that crosses the boundary.
   always_comb begin
      step_wraps = 1'b0;
      next_digit = digit;
      if (up) begin
         step_wraps = (digit == MAX_DIGIT);
         next_digit = step_wraps ? 4'd0 : digit + 4'd1;
      end else begin
         step_wraps = (digit == 4'd0);
         next_digit = step_wraps ? MAX_DIGIT : digit - 4'd1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         digit   <= 4'd0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
         div_cnt <= '0;
         speed_q <= 2'b00;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (load) begin
            digit   <= load_digit;
            div_cnt <= reload_val;
            speed_q <= speed;
         end else if (speed != speed_q) begin
            speed_q <= speed;
            div_cnt <= reload_val;
         end else if (enable) begin
            if (div_cnt != '0) begin
               div_cnt <= div_cnt - 1'b1;
            end else begin
               digit   <= next_digit;
               div_cnt <= reload_val;
               tick    <= 1'b1;
               wrap    <= step_wraps;
            end
         end
      end
   end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Scoreboard bench for hex_digit_counter at CLK_HZ=4; expectations are queued as stimulus is driven.
module tb_hex_digit_counter;

   logic       clock;
   logic       resetn;
   logic       enable;
   logic [1:0] speed;
   logic       up;
   logic       load;
   logic [3:0] load_value;
   logic [3:0] digit;
   logic       tick;
   logic       wrap;

   typedef struct {
      logic [3:0] d;
      logic       t;
      logic       w;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   hex_digit_counter #(.CLK_HZ(4), .DIV_W(4)) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .speed(speed), .up(up),
      .load(load), .load_value(load_value), .digit(digit), .tick(tick), .wrap(wrap)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic drive(input logic en, input logic [1:0] spd, input logic u,
                        input logic ld, input logic [3:0] lv);
      enable     = en;
      speed      = spd;
      up         = u;
      load       = ld;
      load_value = lv;
   endtask

   task automatic push(input logic [3:0] d, input logic t, input logic w, input string name);
      exp_t x;
      x.d = d; x.t = t; x.w = w; x.name = name;
      sb.push_back(x);
   endtask

   task automatic step_clk();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive(1'b0, 2'b00, 1'b1, 1'b0, 4'h0);
      #12;
      push(4'h0, 1'b0, 1'b0, "reset_state");
      e = sb.pop_front();
      checks++;
      if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
         failures++;
         $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                  e.name, digit, tick, wrap, e.d, e.t, e.w);
      end
      resetn = 1'b1;
      drive(1'b0, 2'b00, 1'b1, 1'b1, 4'h7);
      push(4'h7, 1'b0, 1'b0, "reset_preload");
      step_clk();
      e = sb.pop_front();
      checks++;
      if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
         failures++;
         $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                  e.name, digit, tick, wrap, e.d, e.t, e.w);
      end
      drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0);
      #2;
      resetn = 1'b0;
      push(4'h0, 1'b0, 1'b0, "reset_async_midcycle");
      #1;
      e = sb.pop_front();
      checks++;
      if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
         failures++;
         $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                  e.name, digit, tick, wrap, e.d, e.t, e.w);
      end
      resetn = 1'b1;
      enable = 1'b0;
   endtask

   task automatic test_count_every_cycle();
      drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0);
      for (int i = 1; i <= 16; i++) begin
         push(4'(i), 1'b1, (i == 16), $sformatf("count_up_%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
   endtask

   task automatic test_speed_change();
      logic [3:0] d;
      d = 4'h0;
      drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i <= 10; i++) begin
         if (i > 0 && i % 4 == 0) d = d + 4'd1;
         push(d, (i > 0 && i % 4 == 0), 1'b0, $sformatf("speed01_c%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
      speed = 2'b11;
      for (int i = 0; i <= 32; i++) begin
         if (i > 0 && i % 16 == 0) d = d + 4'd1;
         push(d, (i > 0 && i % 16 == 0), 1'b0, $sformatf("speed11_c%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
   endtask

   task automatic test_load();
      drive(1'b0, 2'b01, 1'b1, 1'b1, 4'hA);
      push(4'hA, 1'b0, 1'b0, "load_disabled");
      step_clk();
      e = sb.pop_front();
      checks++;
      if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
         failures++;
         $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                  e.name, digit, tick, wrap, e.d, e.t, e.w);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 2'b01, 1'b1, (i == 4), 4'hA);
         push((i == 8) ? 4'hB : 4'hA, (i == 8), 1'b0, $sformatf("load_due_c%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
   endtask

   task automatic test_down_and_hold();
      logic [3:0] d;
      logic       t;
      logic       w;
      for (int i = 0; i < 18; i++) begin
         d = 4'hE; t = 1'b0; w = 1'b0;
         case (i)
            0:  begin drive(1'b0, 2'b00, 1'b0, 1'b1, 4'h0); d = 4'h0; end
            1:  begin drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0); d = 4'hF; t = 1'b1; w = 1'b1; end
            2:  begin t = 1'b1; end
            3:  drive(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            6:  enable = 1'b0;
            16: enable = 1'b1;
            17: begin d = 4'hD; t = 1'b1; end
            default: ;
         endcase
         push(d, t, w, $sformatf("down_hold_c%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
   endtask

   task automatic test_modulus();
      logic [3:0] d;
      logic       t;
      logic       w;
      for (int i = 0; i < 6; i++) begin
         t = 1'b0; w = 1'b0;
`ifdef HEX_COUNTER_BCD_EN
         case (i)
            0: begin drive(1'b0, 2'b00, 1'b1, 1'b1, 4'h8); d = 4'h8; end
            1: begin drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0); d = 4'h9; t = 1'b1; end
            2: begin d = 4'h0; t = 1'b1; w = 1'b1; end
            3: begin drive(1'b0, 2'b00, 1'b1, 1'b1, 4'hC); d = 4'h9; end
            4: begin drive(1'b0, 2'b00, 1'b0, 1'b1, 4'h0); d = 4'h0; end
            default: begin drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0); d = 4'h9; t = 1'b1; w = 1'b1; end
         endcase
`else
         case (i)
            0: begin drive(1'b0, 2'b00, 1'b1, 1'b1, 4'hE); d = 4'hE; end
            1: begin drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0); d = 4'hF; t = 1'b1; end
            2: begin d = 4'h0; t = 1'b1; w = 1'b1; end
            3: begin drive(1'b0, 2'b00, 1'b1, 1'b1, 4'hC); d = 4'hC; end
            4: begin drive(1'b0, 2'b00, 1'b0, 1'b1, 4'h0); d = 4'h0; end
            default: begin drive(1'b1, 2'b00, 1'b0, 1'b0, 4'h0); d = 4'hF; t = 1'b1; w = 1'b1; end
         endcase
`endif
         push(d, t, w, $sformatf("modulus_c%0d", i));
         step_clk();
         e = sb.pop_front();
         checks++;
         if ({digit, tick, wrap} !== {e.d, e.t, e.w}) begin
            failures++;
            $display("[TB] FAIL %s: got digit=%h tick=%b wrap=%b, want digit=%h tick=%b wrap=%b",
                     e.name, digit, tick, wrap, e.d, e.t, e.w);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_every_cycle();
      test_speed_change();
      test_load();
      test_down_and_hold();
      test_modulus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
